// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CORE,
        DBG
    } owner_e;

    localparam logic OWNER_CORE   = 1'b0;
    localparam logic OWNER_DBG    = 1'b1;
    localparam int   LOCK_MAX_DEF = 16;

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return stage: tags the returning memory word with its owner
// and steers it to the matching requester, holding the last value.
module dmem_rd_return
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              rd_i,
    input  logic              tag_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic              v_q;
    logic              tag_q;
    logic [DATA_W-1:0] core_hold_q;
    logic [DATA_W-1:0] dbg_hold_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            v_q         <= 1'b0;
            tag_q       <= OWNER_CORE;
            core_hold_q <= '0;
            dbg_hold_q  <= '0;
        end else begin
            v_q   <= rd_i;
            tag_q <= tag_i;
            if (core_rvalid_o) core_hold_q <= rdata_i;
            if (dbg_rvalid_o)  dbg_hold_q  <= rdata_i;
        end
    end

    assign core_rvalid_o = v_q & (tag_q == OWNER_CORE);
    assign dbg_rvalid_o  = v_q & (tag_q == OWNER_DBG);
    assign core_rdata_o  = core_rvalid_o ? rdata_i : core_hold_q;
    assign dbg_rdata_o   = dbg_rvalid_o  ? rdata_i : dbg_hold_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the core data-memory port with a
// bounded debug lock, registered command and tagged read return.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LOCK_MAX - 1);

    owner_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick_dbg;
    logic               gnt_c, gnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= OWNER_DBG;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pick_dbg = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_req && dbg_req) pick_dbg = (last_q == OWNER_CORE);
                else                     pick_dbg = dbg_req;
            end
            CORE: pick_dbg = dbg_req;
            DBG: begin
                // Locked bursts yield to a waiting core once the bound is hit
                if (dbg_lock && dbg_req && (cnt_q != CNT_TOP || !core_req))
                    pick_dbg = 1'b1;
                else
                    pick_dbg = dbg_req && !core_req;
            end
            default: pick_dbg = 1'b0;
        endcase
        gnt_c   = core_req & ~pick_dbg;
        gnt_d   = dbg_req & pick_dbg;
        state_d = gnt_c ? CORE : (gnt_d ? DBG : IDLE);
        last_d  = gnt_c ? OWNER_CORE : (gnt_d ? OWNER_DBG : last_q);
        cnt_d   = '0;
        if (gnt_d && state_q == DBG && dbg_lock)
            cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
    end

    assign core_gnt   = reset & gnt_c;
    assign dbg_gnt    = reset & gnt_d;
    assign core_stall = reset & core_req & ~gnt_c;

    logic              wr_q, rd_q, tag_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_sel;

    always_comb begin
        we_sel  = gnt_d ? dbg_we : core_we;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_d) begin
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
        end else if (gnt_c) begin
            addr_d  = core_addr;
            wdata_d = core_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            tag_q   <= OWNER_CORE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wr_q    <= (gnt_c | gnt_d) & we_sel;
            rd_q    <= (gnt_c | gnt_d) & ~we_sel;
            tag_q   <= gnt_d ? OWNER_DBG : OWNER_CORE;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_wr      = wr_q;
    assign mem_rd      = rd_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;

    dmem_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk           (clk),
        .rst_ni        (reset),
        .rd_i          (rd_q),
        .tag_i         (tag_q),
        .rdata_i       (mem_rd_data),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .dbg_rvalid_o  (dbg_rvalid),
        .dbg_rdata_o   (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for the data-memory port arbiter (LOCK_MAX = 4).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_wr, mem_rd;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;

    logic [31:0] mem [512];
    int n_checks = 0;
    int n_fail   = 0;
    int stalls;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Synchronous memory: data is available the cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd) mem_rd_data <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req  = 0; dbg_we  = 0; dbg_addr  = '0; dbg_wdata  = '0;
        dbg_lock = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h5A000000 | i;
        mem[16] = 32'hDEADBEEF;
        mem[1]  = 32'h11111111;
        mem[2]  = 32'h22222222;
        mem[3]  = 32'h33333333;
        mem_rd_data = '0;
        idle_inputs();
        reset = 0;
        tick();
        tick();
        settle();
        check("rst_ctl", {25'd0, core_gnt, dbg_gnt, core_stall, core_rvalid,
                          dbg_rvalid, mem_wr, mem_rd}, 32'd0);
        check("rst_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wr_data, 32'd0);
        check("rst_crdata", core_rdata, 32'd0);
        check("rst_drdata", dbg_rdata, 32'd0);
        reset = 1;
        tick();

        // core-only read
        core_req = 1; core_we = 0; core_addr = 9'h010;
        settle();
        check("t1_gnt", {31'd0, core_gnt}, 32'd1);
        check("t1_stall", {31'd0, core_stall}, 32'd0);
        tick();
        core_req = 0;
        settle();
        check("t1_rd", {30'd0, mem_rd, mem_wr}, 32'd2);
        check("t1_addr", {23'd0, mem_addr}, 32'h010);
        check("t1_rv1", {31'd0, core_rvalid}, 32'd0);
        tick();
        settle();
        check("t1_rv2", {30'd0, core_rvalid, dbg_rvalid}, 32'd2);
        check("t1_rdata", core_rdata, 32'hDEADBEEF);
        tick();
        settle();
        check("t1_rv3", {31'd0, core_rvalid}, 32'd0);
        check("t1_hold", core_rdata, 32'hDEADBEEF);

        // write conflict after reset: core first
        do_reset();
        core_req = 1; core_we = 1; core_addr = 9'h004; core_wdata = 32'hA0A0A0A0;
        dbg_req  = 1; dbg_we  = 1; dbg_addr  = 9'h008; dbg_wdata  = 32'hB0B0B0B0;
        settle();
        check("t2_gnt0", {30'd0, core_gnt, dbg_gnt}, 32'd2);
        check("t2_stall0", {31'd0, core_stall}, 32'd0);
        tick();
        core_req = 0;
        settle();
        check("t2_gnt1", {30'd0, core_gnt, dbg_gnt}, 32'd1);
        check("t2_cmd1", {mem_wr, mem_rd, 21'd0, mem_addr}, {2'b10, 21'd0, 9'h004});
        check("t2_wd1", mem_wr_data, 32'hA0A0A0A0);
        tick();
        dbg_req = 0;
        settle();
        check("t2_cmd2", {mem_wr, mem_rd, 21'd0, mem_addr}, {2'b10, 21'd0, 9'h008});
        check("t2_wd2", mem_wr_data, 32'hB0B0B0B0);
        check("t2_rv2", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
        tick();
        settle();
        check("t2_rv3", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
        check("t2_cmd3", {30'd0, mem_wr, mem_rd}, 32'd0);
        tick();

        // sustained conflict without lock: strict alternation
        core_req = 1; core_we = 1; dbg_req = 1; dbg_we = 1;
        for (int k = 0; k < 6; k++) begin
            settle();
            check($sformatf("t3_gnt%0d", k), {30'd0, core_gnt, dbg_gnt},
                  (k % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("t3_stall%0d", k), {31'd0, core_stall},
                  (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        // locked debug burst bounded at LOCK_MAX = 4
        core_req = 1; core_we = 1; dbg_req = 1; dbg_we = 1; dbg_lock = 1;
        stalls = 0;
        for (int k = 0; k < 7; k++) begin
            settle();
            check($sformatf("t4_gnt%0d", k), {30'd0, core_gnt, dbg_gnt},
                  (k == 0 || k == 5) ? 32'd2 : 32'd1);
            if (k < 6 && core_stall) stalls++;
            tick();
        end
        check("t4_stalls", stalls, 32'd4);
        core_req = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("t4_sat%0d", k), {30'd0, core_gnt, dbg_gnt}, 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        // reset during an in-flight debug read
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h005;
        settle();
        check("t5_gnt", {31'd0, dbg_gnt}, 32'd1);
        tick();
        dbg_req = 0; reset = 0;
        settle();
        check("t5_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        reset = 1;
        settle();
        check("t5_ctl", {25'd0, core_gnt, dbg_gnt, core_stall, core_rvalid,
                         dbg_rvalid, mem_wr, mem_rd}, 32'd0);
        check("t5_addr", {23'd0, mem_addr}, 32'd0);
        check("t5_drdata", dbg_rdata, 32'd0);
        check("t5_crdata", core_rdata, 32'd0);
        tick();
        settle();
        check("t5_rv3", {31'd0, dbg_rvalid}, 32'd0);
        tick();

        // back-to-back interleaved reads
        core_req = 1; core_we = 0; core_addr = 9'h001;
        settle();
        check("t6_g0", {30'd0, core_gnt, dbg_gnt}, 32'd2);
        tick();
        core_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h002;
        settle();
        check("t6_g1", {30'd0, core_gnt, dbg_gnt}, 32'd1);
        tick();
        dbg_req = 0; core_req = 1; core_addr = 9'h003;
        settle();
        check("t6_g2", {30'd0, core_gnt, dbg_gnt}, 32'd2);
        check("t6_rv2", {30'd0, core_rvalid, dbg_rvalid}, 32'd2);
        check("t6_rd2", core_rdata, 32'h11111111);
        tick();
        core_req = 0;
        settle();
        check("t6_rv3", {30'd0, core_rvalid, dbg_rvalid}, 32'd1);
        check("t6_rd3", dbg_rdata, 32'h22222222);
        check("t6_hold3", core_rdata, 32'h11111111);
        tick();
        settle();
        check("t6_rv4", {30'd0, core_rvalid, dbg_rvalid}, 32'd2);
        check("t6_rd4", core_rdata, 32'h33333333);
        check("t6_hold4", dbg_rdata, 32'h22222222);
        tick();
        settle();
        check("t6_rv5", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
